// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle memory-to-memory CPU: default widths,
// opcode values, FSM state codes and small instruction-field helpers.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W  = 16;
    localparam int unsigned CPU_ADDR_W  = 6;
    localparam int unsigned CPU_PC_INIT = 8;
    localparam int unsigned CPU_SP_INIT = 63;

    // Opcodes; every value not listed (DIV included) executes as a NOP.
    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_STOP = 4'hF;

    // C field value that turns MOV into its two-word immediate form.
    localparam logic [3:0] IMM_SEL = 4'b1000;

    // FSM state codes, visible on the debug port.
    localparam int unsigned STATE_W = 4;
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_RDB_PTR = 4'd2;
    localparam logic [3:0] S_RDB     = 4'd3;
    localparam logic [3:0] S_RDC_PTR = 4'd4;
    localparam logic [3:0] S_RDC     = 4'd5;
    localparam logic [3:0] S_IMM     = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_WA_PTR  = 4'd8;
    localparam logic [3:0] S_WRITE   = 4'd9;
    localparam logic [3:0] S_OUT_RD  = 4'd10;
    localparam logic [3:0] S_STOP    = 4'd11;

    // Operand nibble: bit 3 selects indirection, bits 2:0 name one of words 0-7.
    function automatic logic is_ind(input logic [3:0] nib);
        return nib[3];
    endfunction

    // Opcodes that read B (and, except MOV, C) from memory.
    function automatic logic reads_b(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/cpu_register.sv
// Generic loadable register with clear, load, increment and decrement.
// Used for pc, sp, ir, the output port and the a/b/c operand temporaries.
module cpu_register #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over load, load over increment, increment over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INIT;
        end else if (cl) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end else if (dec) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit memory-to-memory CPU. Words 0-7 of the unified memory act as
// the register file; every operand is fetched through the single memory port, so
// each instruction walks FETCH, DECODE, optional pointer/operand reads, EXEC and a
// single-cycle WRITE (or OUT_RD). Skipped operands cost no cycles.
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = CPU_DATA_W,
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned PC_INIT = CPU_PC_INIT,
    parameter int unsigned SP_INIT = CPU_SP_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp,
    output logic [31:0]       state
);

    logic [STATE_W-1:0] state_q, state_d;

    logic [ADDR_W-1:0] pc_q, sp_q;
    logic [DATA_W-1:0] ir_q, out_q, a_q, b_q, c_q;
    logic [DATA_W-1:0] alu_res;

    logic pc_inc, ir_ld, out_ld, a_ld, b_ld, c_ld;

    logic [3:0] op, fld_a, fld_b, fld_c;

    assign op    = ir_q[15:12];
    assign fld_a = ir_q[11:8];
    assign fld_b = ir_q[7:4];
    assign fld_c = ir_q[3:0];

    // Direct address of a register-file word named by an operand nibble.
    function automatic logic [ADDR_W-1:0] reg_addr(input logic [3:0] nib);
        return ADDR_W'(nib[2:0]);
    endfunction

    cpu_register #(
        .WIDTH (ADDR_W),
        .INIT  (ADDR_W'(PC_INIT))
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (1'b0),
        .inc   (pc_inc),
        .dec   (1'b0),
        .d     ('0),
        .q     (pc_q)
    );

    // Stack pointer is reserved for future push/pop and only ever holds its reset value.
    cpu_register #(
        .WIDTH (ADDR_W),
        .INIT  (ADDR_W'(SP_INIT))
    ) u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (1'b0),
        .inc   (1'b0),
        .dec   (1'b0),
        .d     ('0),
        .q     (sp_q)
    );

    cpu_register #(
        .WIDTH (DATA_W),
        .INIT  ('0)
    ) u_ir (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (ir_ld),
        .inc   (1'b0),
        .dec   (1'b0),
        .d     (mem_in),
        .q     (ir_q)
    );

    cpu_register #(
        .WIDTH (DATA_W),
        .INIT  ('0)
    ) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (out_ld),
        .inc   (1'b0),
        .dec   (1'b0),
        .d     (mem_in),
        .q     (out_q)
    );

    // a holds the result between EXEC and WRITE.
    cpu_register #(
        .WIDTH (DATA_W),
        .INIT  ('0)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (a_ld),
        .inc   (1'b0),
        .dec   (1'b0),
        .d     (alu_res),
        .q     (a_q)
    );

    // b first holds B's pointer (if indirect), then B's value or the immediate.
    cpu_register #(
        .WIDTH (DATA_W),
        .INIT  ('0)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (b_ld),
        .inc   (1'b0),
        .dec   (1'b0),
        .d     (mem_in),
        .q     (b_q)
    );

    // c holds C's pointer/value, and after EXEC is reused for A's indirect pointer.
    cpu_register #(
        .WIDTH (DATA_W),
        .INIT  ('0)
    ) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (1'b0),
        .ld    (c_ld),
        .inc   (1'b0),
        .dec   (1'b0),
        .d     (mem_in),
        .q     (c_q)
    );

    // Result of the current instruction; unsigned, wraps modulo 2^DATA_W.
    always_comb begin
        alu_res = b_q;
        unique case (op)
            OP_ADD:  alu_res = b_q + c_q;
            OP_SUB:  alu_res = b_q - c_q;
            OP_MUL:  alu_res = b_q * c_q;
            OP_IN:   alu_res = in;
            default: alu_res = b_q;
        endcase
    end

    // FSM next state, memory bus and register load strobes.
    always_comb begin
        state_d  = state_q;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        pc_inc   = 1'b0;
        ir_ld    = 1'b0;
        out_ld   = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        c_ld     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_addr = pc_q;
                ir_ld    = 1'b1;
                pc_inc   = 1'b1;
                state_d  = S_DECODE;
            end

            S_DECODE: begin
                if (op == OP_MOV && fld_c == IMM_SEL) begin
                    state_d = S_IMM;
                end else if (reads_b(op)) begin
                    state_d = is_ind(fld_b) ? S_RDB_PTR : S_RDB;
                end else if (op == OP_IN) begin
                    state_d = S_EXEC;
                end else if (op == OP_OUT) begin
                    state_d = is_ind(fld_a) ? S_WA_PTR : S_OUT_RD;
                end else if (op == OP_STOP) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_RDB_PTR: begin
                mem_addr = reg_addr(fld_b);
                b_ld     = 1'b1;
                state_d  = S_RDB;
            end

            S_RDB: begin
                mem_addr = is_ind(fld_b) ? b_q[ADDR_W-1:0] : reg_addr(fld_b);
                b_ld     = 1'b1;
                if (op == OP_MOV) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = is_ind(fld_c) ? S_RDC_PTR : S_RDC;
                end
            end

            S_RDC_PTR: begin
                mem_addr = reg_addr(fld_c);
                c_ld     = 1'b1;
                state_d  = S_RDC;
            end

            S_RDC: begin
                mem_addr = is_ind(fld_c) ? c_q[ADDR_W-1:0] : reg_addr(fld_c);
                c_ld     = 1'b1;
                state_d  = S_EXEC;
            end

            S_IMM: begin
                mem_addr = pc_q;
                b_ld     = 1'b1;
                pc_inc   = 1'b1;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                a_ld    = 1'b1;
                state_d = is_ind(fld_a) ? S_WA_PTR : S_WRITE;
            end

            // The destination pointer is read only after all source reads are done,
            // which is what makes A aliasing B or C safe.
            S_WA_PTR: begin
                mem_addr = reg_addr(fld_a);
                c_ld     = 1'b1;
                state_d  = (op == OP_OUT) ? S_OUT_RD : S_WRITE;
            end

            S_WRITE: begin
                mem_addr = is_ind(fld_a) ? c_q[ADDR_W-1:0] : reg_addr(fld_a);
                mem_data = a_q;
                mem_we   = 1'b1;
                state_d  = S_FETCH;
            end

            S_OUT_RD: begin
                mem_addr = is_ind(fld_a) ? c_q[ADDR_W-1:0] : reg_addr(fld_a);
                out_ld   = 1'b1;
                state_d  = S_FETCH;
            end

            S_STOP: begin
                state_d = S_STOP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign out   = out_q;
    assign pc    = pc_q;
    assign sp    = sp_q;
    assign state = {{(32 - STATE_W){1'b0}}, state_q};

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: a 64-word memory lives here, and an instruction-level reference
// model executes each instruction with plain arithmetic on its own copy of memory.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_in;
    logic [15:0] in_port = '0;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] out;
    logic [5:0]  pc;
    logic [5:0]  sp;
    logic [31:0] state;

    logic [15:0] tb_mem  [64];
    logic [15:0] ref_mem [64];
    logic [5:0]  ref_pc;
    logic [15:0] ref_out;
    bit          ref_halt;
    bit          load_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    cpu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_in   (mem_in),
        .in       (in_port),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out      (out),
        .pc       (pc),
        .sp       (sp),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on rising edge; load_req copies the model image.
    assign mem_in = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] ea(input logic [3:0] nib);
        logic [15:0] ptr;
        if (nib[3]) begin
            ptr = ref_mem[{3'b000, nib[2:0]}];
            return ptr[5:0];
        end
        return {3'b000, nib[2:0]};
    endfunction

    function automatic logic [15:0] rd(input logic [3:0] nib);
        return ref_mem[ea(nib)];
    endfunction

    task automatic ref_exec(input logic [15:0] in_val);
        logic [15:0] ins, bv, cv, v;
        logic        wr;
        ins = ref_mem[ref_pc];
        ref_pc = ref_pc + 6'd1;
        bv = rd(ins[7:4]);
        cv = rd(ins[3:0]);
        v  = '0;
        wr = 1'b0;
        case (ins[15:12])
            4'h0: begin
                wr = 1'b1;
                if (ins[3:0] == 4'b1000) begin
                    v = ref_mem[ref_pc];
                    ref_pc = ref_pc + 6'd1;
                end else begin
                    v = bv;
                end
            end
            4'h1: begin wr = 1'b1; v = bv + cv; end
            4'h2: begin wr = 1'b1; v = bv - cv; end
            4'h3: begin wr = 1'b1; v = bv * cv; end
            4'h7: begin wr = 1'b1; v = in_val; end
            4'h8: ref_out = rd(ins[11:8]);
            4'hF: ref_halt = 1'b1;
            default: ;
        endcase
        if (wr) ref_mem[ea(ins[11:8])] = v;
    endtask

    // ---------------- helpers ----------------
    task automatic clear_mem();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'd8);
        check("rst_sp", 32'(sp), 32'd63);
        check("rst_out", 32'(out), 32'd0);
        check("rst_state", state, 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        load_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        rst_n    = 1'b1;
        ref_pc   = 6'd8;
        ref_out  = '0;
        ref_halt = 1'b0;
    endtask

    // Run one instruction on DUT and model, then compare architectural state.
    task automatic step(input string tag);
        bit done;
        int diffs;
        ref_exec(in_port);
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (state == 32'd0 || state == 32'd11) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
        check({tag, "_mem"}, 32'(diffs), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'(ref_pc));
        check({tag, "_out"}, 32'(out), 32'(ref_out));
        check({tag, "_state"}, state, ref_halt ? 32'd11 : 32'd0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] ops [9];
        logic [15:0] w;
        ops = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h6};
        w = 16'($urandom);
        w[15:12] = ops[$urandom_range(0, 8)];
        if (w[15:12] == 4'h0 && $urandom_range(0, 2) == 0) w[3:0] = 4'b1000;
        return w;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int bad;
        logic [5:0] pc_hold;
        bit found;

        // Immediate MOV: the C field 1000 selects the two-word form.
        clear_mem();
        ref_mem[8] = 16'h0008; ref_mem[9] = 16'd5; ref_mem[10] = 16'hF000;
        apply_reset();
        step("mov_imm");
        check("mov_imm_r0", 32'(tb_mem[0]), 32'd5);
        check("mov_imm_pc10", 32'(pc), 32'd10);

        // Arithmetic: ADD, MUL, then SUB r3 = r1 - r2 = 3 - 4 wraps.
        clear_mem();
        ref_mem[1] = 16'd3; ref_mem[2] = 16'd4;
        ref_mem[8] = 16'h1312; ref_mem[9] = 16'h3312; ref_mem[10] = 16'h2312;
        ref_mem[11] = 16'hF000;
        apply_reset();
        step("add");
        check("add_r3", 32'(tb_mem[3]), 32'd7);
        step("mul");
        check("mul_r3", 32'(tb_mem[3]), 32'd12);
        step("sub");
        check("sub_r3", 32'(tb_mem[3]), 32'hFFFF);

        // Indirect source, indirect destination, full aliasing.
        clear_mem();
        ref_mem[1] = 16'd20; ref_mem[20] = 16'd9; ref_mem[3] = 16'h1234;
        ref_mem[8] = 16'h0290; ref_mem[9] = 16'h0930; ref_mem[10] = 16'h1111;
        ref_mem[11] = 16'hF000;
        apply_reset();
        step("mov_ind_src");
        check("ind_src_r2", 32'(tb_mem[2]), 32'd9);
        step("mov_ind_dst");
        check("ind_dst_m20", 32'(tb_mem[20]), 32'h1234);
        step("alias");
        check("alias_r1", 32'(tb_mem[1]), 32'd40);

        // IN, OUT, NOP, STOP.
        clear_mem();
        ref_mem[8] = 16'h7400; ref_mem[9] = 16'h8400; ref_mem[10] = 16'h4123;
        ref_mem[11] = 16'hF000;
        apply_reset();
        in_port = 16'hABCD;
        step("in");
        check("in_r4", 32'(tb_mem[4]), 32'hABCD);
        in_port = 16'h0000;
        step("out");
        check("out_port", 32'(out), 32'hABCD);
        step("nop");
        check("nop_pc", 32'(pc), 32'd11);
        step("stop");
        check("stop_state", state, 32'd11);
        pc_hold = pc;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state != 32'd11 || pc != pc_hold || mem_we != 1'b0) bad++;
        end
        check("stop_hold", 32'(bad), 32'd0);

        // Reset during EXEC: state returns to FETCH, pc to 8, no write lands.
        clear_mem();
        ref_mem[1] = 16'd3; ref_mem[2] = 16'd4; ref_mem[8] = 16'h1312;
        apply_reset();
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (state == 32'd7) found = 1'b1;
        end
        check("exec_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_state", state, 32'd0);
        check("midrst_pc", 32'(pc), 32'd8);
        check("midrst_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("midrst_nowrite", 32'(tb_mem[3]), 32'd0);

        // Random programs over random memory contents.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
            for (int i = 0; i < 12; i++) ref_mem[8 + i] = rand_instr();
            ref_mem[20] = 16'hF000;
            apply_reset();
            for (int i = 0; i < 16 && !ref_halt; i++) begin
                in_port = 16'($urandom);
                step($sformatf("rnd%0d_%0d", p, i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
